// File: rtl/vedic_dot_accumulator.sv
// Streaming dot-product: registered 8x8 Vedic multiply feeding an ACC_W-bit accumulator.
// Latency: last element accepted at edge T gives out_valid high after edge T+1.
// Backpressure: in_ready = ~(out_valid & ~out_ready); stage 1 and accumulator freeze on stall.

// 2x2 Vedic cell: vertical and crosswise partial products.
// Latency: combinational.
// Backpressure: none.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_lo, cross_hi, c1;

  assign cross_lo = a[1] & b[0];
  assign cross_hi = a[0] & b[1];
  assign c1       = cross_lo & cross_hi;
  assign p[0]     = a[0] & b[0];
  assign p[1]     = cross_lo ^ cross_hi;
  assign p[2]     = (a[1] & b[1]) ^ c1;
  assign p[3]     = (a[1] & b[1]) & c1;
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells.
// Latency: combinational.
// Backpressure: none.
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {q3, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00};
endmodule

// 8x8 Vedic multiplier built from four 4x4 blocks; full 16-bit product, never overflows.
// Latency: combinational.
// Backpressure: none.
module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {q3, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0};
endmodule

// Dot-product accumulator stage; one result per vector of up to VEC_LEN pairs.
// Latency: 2 edges from last-element accept to out_valid.
// Backpressure: a held, unconsumed result stalls input and freezes all internal state.
module vedic_dot_accumulator #(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [8:0]       out_count,
  output logic             out_overflow
);
  localparam logic [8:0] LEN = 9'(VEC_LEN);

  logic             stall, accept, step, last_elem, carry;
  logic             s1_valid, s1_last;
  logic [7:0]       s1_a, s1_b;
  logic [15:0]      prod;
  logic [ACC_W:0]   nsum;
  logic [ACC_W-1:0] acc;
  logic [8:0]       cnt, cnt_inc;
  logic             ovf;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Multiplier only ever sees registered operands, keeping the path to mult + add.
  vedic_8X8 u_mul (.a(s1_a), .b(s1_b), .p(prod));

  assign nsum      = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
  assign carry     = nsum[ACC_W];
  assign cnt_inc   = cnt + 9'd1;
  // An in_last on the VEC_LEN-th element coincides with the count end: one result.
  assign last_elem = s1_last | (cnt_inc == LEN);
  assign step      = s1_valid & ~stall;

  // Stage 1 operand register; holds everything while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 8'd0;
      s1_b     <= 8'd0;
      s1_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_last  <= in_last;
    end
  end

  // Running sum, element count and sticky carry for the vector in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= 9'd0;
      ovf <= 1'b0;
    end else if (step) begin
      if (last_elem) begin
        acc <= '0;
        cnt <= 9'd0;
        ovf <= 1'b0;
      end else begin
        acc <= nsum[ACC_W-1:0];
        cnt <= cnt_inc;
        ovf <= ovf | carry;
      end
    end
  end

  // Result register; a new result may replace one being consumed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= 9'd0;
      out_overflow <= 1'b0;
    end else if (step && last_elem) begin
      out_valid    <= 1'b1;
      out_sum      <= nsum[ACC_W-1:0];
      out_count    <= cnt_inc;
      out_overflow <= ovf | carry;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end
endmodule

// File: doc/vedic_dot_accumulator.md
# vedic_dot_accumulator

Streaming dot-product stage built around the byte Vedic multiplier. It accepts 8-bit operand pairs over a valid/ready handshake, registers each pair, multiplies it through an internal `vedic_8X8` instance, and accumulates the 16-bit products. After each vector it presents one accumulated sum to downstream logic on a second valid/ready handshake. It is the consumer stage directly after `vedic_8X8` and converts its combinational product into a pipelined, flow-controlled MAC result.

## Interface
- `VEC_LEN`, default 4: elements per vector when `in_last` is not asserted; legal range 1..256.
- `ACC_W`, default 18: accumulator/result width; legal range 16..32. It is overflow-free when ACC_W ≥ 16+ceil(log2(VEC_LEN)).

- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: stage can accept a pair.
- `in_a` input 8: unsigned multiplicand.
- `in_b` input 8: unsigned multiplier.
- `in_last` input 1: this pair ends the vector early.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts result.
- `out_sum` output ACC_W: sum of products, modulo 2^ACC_W.
- `out_count` output 9: number of elements in the vector (1..256).
- `out_overflow` output 1: sticky flag for the vector; a carry was lost out of ACC_W.

## Operation
- Accept: a pair is accepted on a rising edge where `in_valid & in_ready`.
- Stall: `stall = out_valid & ~out_ready`. `in_ready = ~stall`, combinational, with no dependence on `in_valid`.
- Stage 1 register:
  - On a non-stall edge it loads `s1_valid` = accept, and captures `in_a`, `in_b` and `in_last`.
  - On a stall edge all of stage 1 holds.
- Stage 2:
  - `prod` = `vedic_8X8(s1_a, s1_b)`, 16 bits, zero-extended to ACC_W+1.
  - `nsum = acc + prod`. Bit ACC_W is the carry.
- Element counter `cnt` (9 bits) counts elements already accumulated in the current vector.
- Final element condition: `s1_last | (cnt+1 == VEC_LEN)`.
- On an edge with `s1_valid & ~stall`:
  - Non-final element: `acc <= nsum[ACC_W-1:0]`, `cnt <= cnt+1`, `ovf <= ovf | carry`.
  - Final element: `out_sum <= nsum[ACC_W-1:0]`, `out_count <= cnt+1`, `out_overflow <= ovf | carry`, `out_valid <= 1`. Then `acc`, `cnt` and `ovf` clear to 0.
- If `out_valid & out_ready` and no final element loads on that edge, `out_valid` clears.
- Final load in the same cycle as `out_ready=1`: the new result replaces the old one and `out_valid` stays 1. No bubble and no loss.
- `out_sum`, `out_count` and `out_overflow` hold stable while `out_valid & ~out_ready`.
- `in_last` on the VEC_LEN-th element is redundant and is treated as a single end. `in_last` on element 1 gives `out_count=1`.
- A vector longer than VEC_LEN without `in_last` is split into consecutive VEC_LEN-element results.

## Timing
- Reset values: `out_valid=0`, `out_sum=0`, `out_count=0`, `out_overflow=0`, `s1_valid=0`, `acc=0`, `cnt=0`, `ovf=0`. `in_ready=1` in the cycle after reset deasserts.
- Reset during a partial vector or a held result discards all state. No result is emitted for the discarded data.
- While `rst=1`, `in_ready` may read 1, but accepted pairs are discarded.
- Latency: when the last element is accepted at edge T, `out_valid` is high after edge T+1.
- Throughput: one pair per cycle while `out_ready=1`. Results can issue every cycle when VEC_LEN=1.
- Backpressure: `in_ready` drops in the same cycle `out_valid & ~out_ready` holds. Stage 1 and the accumulator freeze.
- Each pair feeds `vedic_8X8` from registers only. The critical path is multiplier plus ACC_W-bit add.

## Test plan
- Full-scale vector: defaults, 4× (255,255), `out_ready=1` → one result `out_sum=260100`, `out_count=4`, `out_overflow=0`, 2 cycles after the 4th accept.
- Early last: (9,27), then (27,21) with `in_last=1` → `out_sum=810`, `out_count=2`. The next vector (6,7),(3,23),(2,41),(0,0) → `out_sum=193`, `out_count=4`.
- Backpressure: two back-to-back vectors of 4× (1,1), `out_ready=0` → first result 4 is held stable and `in_ready` falls. `out_ready=1` for one cycle → first result consumed, then second result 4 appears. Exactly 2 results, no duplicates.
- Overflow: `ACC_W=16`, VEC_LEN=2, 2× (255,255) → `out_sum=64514`, `out_overflow=1`. The next vector 2× (1,1) → `out_sum=2`, `out_overflow=0`.
- Reset mid-vector: defaults, accept (10,10),(10,10), pulse `rst` for 1 cycle, then send 4× (2,3) → single result `out_sum=24`, `out_count=4`.
- Zero and single: VEC_LEN=1, stream (0,0),(255,1),(16,16) with `out_ready=1` → results 0, 255, 256 on consecutive cycles, each `out_count=1`.
